// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller: buffers plaintext blocks and sequences an external
// AES-128 core in ECB, CBC or CTR mode, one block in flight at a time.
module aes_mode_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CTR_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [1:0]   cfg_mode,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  output logic         busy,
  output logic         err_mode,
  output logic [31:0]  blk_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthC = (AW + 1)'(FIFO_DEPTH);
  localparam logic [127:0] CtrMask = {128{1'b1}} >> (128 - CTR_WIDTH);
  localparam logic [1:0] ModeEcb = 2'b00;
  localparam logic [1:0] ModeCbc = 2'b01;
  localparam logic [1:0] ModeCtr = 2'b10;
  localparam logic [1:0] ModeRsv = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StOut} state_e;
  state_e state_q, state_d;

  logic [127:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, fifo_empty, capture, cfg_window;
  logic [127:0]  head, blk_sel, out_sel, ctr_inc;

  logic [1:0]   mode_q;
  logic [127:0] key_q, chain_q, ctr_q;
  logic [127:0] out_data_q, core_block_q, core_key_q;
  logic         out_valid_q, err_q;
  logic [31:0]  blk_count_q;

  assign head       = mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign in_ready   = rst & (count_q < DepthC);
  assign push       = in_valid & in_ready;
  // The head is only popped at capture, so WAIT always has a valid head.
  assign capture    = (state_q == StWait) & core_done;
  assign pop        = capture;
  assign cfg_window = cfg_load & (state_q == StIdle) & fifo_empty;

  assign core_start = (state_q == StLoad);
  assign busy       = (state_q != StIdle) | ~fifo_empty;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign core_block = core_block_q;
  assign core_key   = core_key_q;
  assign err_mode   = err_q;
  assign blk_count  = blk_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!fifo_empty) state_d = StLoad;
      StLoad:  state_d = StWait;
      StWait:  if (core_done) state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    blk_sel = head;
    case (mode_q)
      ModeCbc: blk_sel = head ^ chain_q;
      ModeCtr: blk_sel = ctr_q;
      default: blk_sel = head;
    endcase
    out_sel = (mode_q == ModeCtr) ? (head ^ core_ct) : core_ct;
    // Only the low CTR_WIDTH bits count; the upper bits are a fixed nonce.
    ctr_inc = (ctr_q & ~CtrMask) | ((ctr_q + 128'd1) & CtrMask);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= ModeEcb;
      key_q        <= '0;
      chain_q      <= '0;
      ctr_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      core_block_q <= '0;
      core_key_q   <= '0;
      err_q        <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      // Operands are frozen on IDLE->LOAD and held through WAIT.
      if (state_q == StIdle && !fifo_empty) begin
        core_block_q <= blk_sel;
        core_key_q   <= key_q;
      end
      if (capture) begin
        out_data_q  <= out_sel;
        out_valid_q <= 1'b1;
        if (mode_q == ModeCbc) chain_q <= core_ct;
        if (mode_q == ModeCtr) ctr_q <= ctr_inc;
      end else if (state_q == StOut && out_ready) begin
        out_valid_q <= 1'b0;
        blk_count_q <= blk_count_q + 32'd1;
      end
      if (cfg_window) begin
        if (cfg_mode == ModeRsv) begin
          err_q <= 1'b1;
        end else begin
          mode_q      <= cfg_mode;
          key_q       <= cfg_key;
          chain_q     <= cfg_iv;
          ctr_q       <= cfg_iv;
          blk_count_q <= '0;
          err_q       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/aes_mode_ctrl.md
AES_MODE_CTRL -- requirements
Module: aes_mode_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning input block FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CTR_WIDTH, default 32, meaning counter-increment width in CTR mode (1..128).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  pulse: latch cfg_mode/cfg_key/cfg_iv.
- cfg_mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved.
- cfg_key  in  128  AES key.
- cfg_iv  in  128  CBC IV / CTR initial counter.
- in_valid  in  1  input block valid.
- in_ready  out  1  FIFO can accept.
- in_data  in  128  plaintext block.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  128  ciphertext block.
- core_start  out  1  one-cycle start to external AES-128 core.
- core_key  out  128  key to core.
- core_block  out  128  block to core.
- core_done  in  1  core result valid.
- core_ct  in  128  core result.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- err_mode  out  1  last cfg_load was rejected.
- blk_count  out  32  blocks output since last accepted cfg_load.

Function
REQ-004 SHALL push in_data when in_valid && in_ready; in_ready SHALL equal (FIFO count < FIFO_DEPTH) from registered count.
REQ-005 SHALL use FSM IDLE -> LOAD -> WAIT -> OUT -> IDLE.
- IDLE: FIFO non-empty -> LOAD next edge.
- LOAD: core_start=1 for exactly this cycle -> WAIT.
- WAIT: core_done sampled 1 -> capture result, pop FIFO head, out_valid=1 -> OUT.
- OUT: out_ready=1 -> out_valid=0, blk_count+1 (mod 2^32) -> IDLE.
REQ-006 SHALL hold core_block and core_key stable from LOAD until leaving WAIT.
REQ-007 ECB SHALL drive core_block = head; out_data = core_ct.
REQ-008 CBC SHALL drive core_block = head XOR chain; out_data = core_ct; chain := core_ct at capture; chain := cfg_iv on cfg_load.
REQ-009 CTR SHALL drive core_block = ctr; out_data = head XOR core_ct; at capture ctr[CTR_WIDTH-1:0] increments mod 2^CTR_WIDTH, upper bits unchanged; ctr := cfg_iv on cfg_load.
REQ-010 SHALL accept cfg_load only in IDLE with FIFO empty and cfg_mode != 11: latch mode/key/iv, clear blk_count and err_mode.
REQ-011 cfg_load with cfg_mode == 11 in IDLE/empty SHALL leave config, chain, ctr and blk_count unchanged and set err_mode=1.
REQ-012 cfg_load while busy SHALL be ignored entirely, err_mode unchanged.
REQ-013 SHALL ignore core_done outside WAIT.
REQ-014 SHALL keep out_valid/out_data stable while out_valid && !out_ready.
REQ-015 SHALL allow a push and a pop in the same cycle, count unchanged; a pop SHALL never occur with FIFO empty.
REQ-016 Minimum per-block latency SHALL be core latency + 3 cycles (IDLE, LOAD, OUT).

Reset
REQ-017 rst low SHALL asynchronously force: IDLE, FIFO empty, in_ready=0 while low then 1, out_valid=0, out_data=0, core_start=0, core_key=0, core_block=0, busy=0, err_mode=0, blk_count=0, mode=ECB, chain=0, ctr=0.
REQ-018 Reset mid-WAIT SHALL discard the in-flight block; a later core_done SHALL be ignored per REQ-013.

Verification
REQ-019 ECB: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, blk_count=1.
REQ-020 CBC, IV 0, same key: blocks 00112233...eeff then 0 -> second core_block = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-021 CTR, iv low word ffffffff, upper 96 bits 0xAA-pattern -> second core_block low word 00000000, upper 96 bits unchanged.
REQ-022 out_ready=0, push 5 blocks -> in_ready=0 after FIFO_DEPTH pushes while first result is held, one core_start total, out_data stable.
REQ-023 cfg_mode=11 cfg_load -> err_mode=1, previous mode persists; cfg_load while busy -> no effect.
REQ-024 rst low during WAIT, then core_done pulse -> out_valid stays 0, blk_count=0, FSM IDLE.
